// File: rtl/evr_rx_phase_lock_if.sv
// Signal bundle between the EVR RX phase-lock controller and the GTX/bitslide logic.
// Optional stats ports are present only when EVR_PHASE_LOCK_STATS_EN is defined.
interface evr_rx_phase_lock_if #(
    parameter int SLIDE_W = 5,
    parameter int RETRY_W = 10
);
    logic               enable_i;
    logic [SLIDE_W-1:0] target_slide_i;
    logic               serdes_ready_i;
    logic               synced_i;
    logic [SLIDE_W-1:0] bitslide_i;
    logic               gtx_rx_reset_o;
    logic               locked_o;
    logic               fail_o;
    logic [RETRY_W-1:0] retry_cnt_o;
    logic [2:0]         state_o;
`ifdef EVR_PHASE_LOCK_STATS_EN
    logic [15:0]        lock_loss_cnt_o;
    logic [SLIDE_W-1:0] last_slide_o;
`endif

    modport master (
        input  enable_i, target_slide_i, serdes_ready_i, synced_i, bitslide_i,
        output gtx_rx_reset_o, locked_o, fail_o, retry_cnt_o, state_o
`ifdef EVR_PHASE_LOCK_STATS_EN
        , output lock_loss_cnt_o, last_slide_o
`endif
    );

    modport slave (
        output enable_i, target_slide_i, serdes_ready_i, synced_i, bitslide_i,
        input  gtx_rx_reset_o, locked_o, fail_o, retry_cnt_o, state_o
`ifdef EVR_PHASE_LOCK_STATS_EN
        , input lock_loss_cnt_o, last_slide_o
`endif
    );
endinterface

// File: rtl/evr_rx_phase_lock.sv
// RX phase-lock controller: pulses GTX RX reset until bitslide matches the target.
// Define EVR_PHASE_LOCK_STATS_EN to add lock-loss counter and last-bitslide capture.
//
// state     | meaning
// IDLE      | disabled, outputs low, retry count cleared
// WAIT_RDY  | waiting for serdes ready
// WAIT_SYNC | waiting for comma sync, timeout forces a retry
// SETTLE    | sync must hold for SETTLE cycles
// CHECK     | compare bitslide with latched target
// RESET     | GTX RX reset held for RST_HOLD cycles
// LOCKED    | phase locked, monitoring for lock loss
// FAIL      | retry limit exhausted, waits for enable low
module evr_rx_phase_lock #(
    parameter int SLIDE_W      = 5,
    parameter int RETRY_W      = 10,
    parameter int RST_HOLD     = 16,
    parameter int SYNC_TIMEOUT = 65535,
    parameter int SETTLE       = 255
) (
    input  logic                gtp_rx_clk_i,
    input  logic                gtp_rst_i,
    evr_rx_phase_lock_if.master bus
);
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam int SYNC_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam int SETL_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TMR_A  = (HOLD_W > SYNC_W) ? HOLD_W : SYNC_W;
    localparam int TMR_W  = (TMR_A > SETL_W) ? TMR_A : SETL_W;

    localparam logic [TMR_W-1:0]   HOLD_LOAD = TMR_W'(RST_HOLD - 1);
    localparam logic [TMR_W-1:0]   SYNC_LOAD = TMR_W'(SYNC_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   SETL_LOAD = TMR_W'(SETTLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_RDY  = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_CHECK     = 3'd4,
        ST_RESET     = 3'd5,
        ST_LOCKED    = 3'd6,
        ST_FAIL      = 3'd7
    } state_t;

    state_t             state, state_nxt;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic [RETRY_W-1:0] retry_cnt, retry_nxt;
    logic [SLIDE_W-1:0] target, target_nxt;
    logic               retry_hit;
    logic               link_ok;
    logic               rx_reset, locked, fail;

    assign link_ok = bus.synced_i & bus.serdes_ready_i;

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        retry_nxt  = retry_cnt;
        target_nxt = target;
        retry_hit  = 1'b0;
        if (!bus.enable_i) begin
            state_nxt = ST_IDLE;
            retry_nxt = '0;
            timer_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    retry_nxt  = '0;
                    target_nxt = bus.target_slide_i;
                    state_nxt  = ST_WAIT_RDY;
                end
                ST_WAIT_RDY:
                    if (bus.serdes_ready_i) begin
                        state_nxt = ST_WAIT_SYNC;
                        timer_nxt = SYNC_LOAD;
                    end
                ST_WAIT_SYNC:
                    if (bus.synced_i) begin
                        state_nxt = ST_SETTLE;
                        timer_nxt = SETL_LOAD;
                    end else if (timer == '0) begin
                        retry_hit = 1'b1;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                ST_SETTLE:
                    if (!link_ok)         state_nxt = ST_WAIT_RDY;
                    else if (timer == '0) state_nxt = ST_CHECK;
                    else                  timer_nxt = timer - 1'b1;
                ST_CHECK:
                    if (bus.bitslide_i == target) state_nxt = ST_LOCKED;
                    else                          retry_hit = 1'b1;
                ST_RESET:
                    if (timer == '0) state_nxt = ST_WAIT_RDY;
                    else             timer_nxt = timer - 1'b1;
                ST_LOCKED:
                    if (!link_ok) begin
                        state_nxt = ST_WAIT_RDY;
                        retry_nxt = '0;
                    end
                ST_FAIL: state_nxt = ST_FAIL;
                default: state_nxt = ST_IDLE;
            endcase
        end
        // Saturate into FAIL rather than letting the retry counter wrap.
        if (retry_hit) begin
            if (retry_cnt == RETRY_MAX) begin
                state_nxt = ST_FAIL;
            end else begin
                retry_nxt = retry_cnt + 1'b1;
                state_nxt = ST_RESET;
                timer_nxt = HOLD_LOAD;
            end
        end
    end

    always_ff @(posedge gtp_rx_clk_i) begin
        if (gtp_rst_i) begin
            state     <= ST_IDLE;
            timer     <= '0;
            retry_cnt <= '0;
            target    <= '0;
            rx_reset  <= 1'b0;
            locked    <= 1'b0;
            fail      <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            retry_cnt <= retry_nxt;
            target    <= target_nxt;
            rx_reset  <= (state_nxt == ST_RESET);
            locked    <= (state_nxt == ST_LOCKED);
            fail      <= (state_nxt == ST_FAIL);
        end
    end

    assign bus.gtx_rx_reset_o = rx_reset;
    assign bus.locked_o       = locked;
    assign bus.fail_o         = fail;
    assign bus.retry_cnt_o    = retry_cnt;
    assign bus.state_o        = state;

`ifdef EVR_PHASE_LOCK_STATS_EN
    logic [15:0]        lock_loss_cnt;
    logic [SLIDE_W-1:0] last_slide;

    always_ff @(posedge gtp_rx_clk_i) begin
        if (gtp_rst_i) begin
            lock_loss_cnt <= '0;
            last_slide    <= '0;
        end else begin
            if (state == ST_LOCKED && state_nxt == ST_WAIT_RDY && lock_loss_cnt != 16'hFFFF)
                lock_loss_cnt <= lock_loss_cnt + 16'd1;
            if (state == ST_CHECK)
                last_slide <= bus.bitslide_i;
        end
    end

    assign bus.lock_loss_cnt_o = lock_loss_cnt;
    assign bus.last_slide_o    = last_slide;
`endif
endmodule

// File: tb/tb_evr_rx_phase_lock.sv
// Directed bench for evr_rx_phase_lock with a cycle-level behavioural reference model.
module tb_evr_rx_phase_lock;
    localparam int SLIDE_W = 5;
    localparam int RETRY_W = 2;
    localparam int RST_HOLD = 16;
    localparam int SYNC_TIMEOUT = 100;
    localparam int SETTLE = 4;
    localparam int RETRY_LIMIT = (1 << RETRY_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;

    evr_rx_phase_lock_if #(.SLIDE_W(SLIDE_W), .RETRY_W(RETRY_W)) bus ();

    evr_rx_phase_lock #(
        .SLIDE_W(SLIDE_W), .RETRY_W(RETRY_W), .RST_HOLD(RST_HOLD),
        .SYNC_TIMEOUT(SYNC_TIMEOUT), .SETTLE(SETTLE)
    ) dut (
        .gtp_rx_clk_i(clk),
        .gtp_rst_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference model: named phases with elapsed-cycle counts.
    int m_state = 0, m_cnt = 0, m_retry = 0, m_target = 0, m_loss = 0, m_last = 0;
    bit m_valid = 0;

    task automatic m_retry_rule();
        if (m_retry == RETRY_LIMIT) m_state = 7;
        else begin m_retry++; m_state = 5; m_cnt = 0; end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0; m_cnt = 0; m_retry = 0; m_target = 0; m_loss = 0; m_last = 0;
            m_valid = 1;
        end else begin
            if (m_state == 4) m_last = int'(bus.bitslide_i);
            if (!bus.enable_i) begin
                m_state = 0; m_retry = 0;
            end else begin
                case (m_state)
                    0: begin m_retry = 0; m_target = int'(bus.target_slide_i); m_state = 1; end
                    1: if (bus.serdes_ready_i) begin m_state = 2; m_cnt = 0; end
                    2: if (bus.synced_i) begin m_state = 3; m_cnt = 0; end
                       else begin m_cnt++; if (m_cnt == SYNC_TIMEOUT) m_retry_rule(); end
                    3: if (!bus.synced_i || !bus.serdes_ready_i) m_state = 1;
                       else begin m_cnt++; if (m_cnt == SETTLE) m_state = 4; end
                    4: if (int'(bus.bitslide_i) == m_target) m_state = 6; else m_retry_rule();
                    5: begin m_cnt++; if (m_cnt == RST_HOLD) m_state = 1; end
                    6: if (!bus.synced_i || !bus.serdes_ready_i) begin
                           m_state = 1; m_retry = 0;
                           if (m_loss < 65535) m_loss++;
                       end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            bit bad;
            bad = (int'(bus.state_o) != m_state) || (bus.gtx_rx_reset_o !== (m_state == 5))
               || (bus.locked_o !== (m_state == 6)) || (bus.fail_o !== (m_state == 7))
               || (int'(bus.retry_cnt_o) != m_retry) || $isunknown(bus.retry_cnt_o);
`ifdef EVR_PHASE_LOCK_STATS_EN
            bad = bad || (int'(bus.lock_loss_cnt_o) != m_loss) || (int'(bus.last_slide_o) != m_last);
`endif
            checks++;
            if (bad)
                $display("FAIL model_cmp t=%0t got st=%0d rst=%b lk=%b fl=%b rc=%0d, need st=%0d rc=%0d",
                         $time, bus.state_o, bus.gtx_rx_reset_o, bus.locked_o, bus.fail_o,
                         bus.retry_cnt_o, m_state, m_retry);
            else
                passes++;
        end
    end

    // Reset-pulse monitor: count, width and rise-to-rise period.
    int  pulse_cnt = 0, cur_w = 0, last_width = 0, last_rise = 0, last_period = 0;
    bit  prev_hi = 0;
    always @(negedge clk) begin
        if (bus.gtx_rx_reset_o === 1'b1) begin
            if (!prev_hi) begin
                pulse_cnt++;
                last_period = cyc - last_rise;
                last_rise = cyc;
                cur_w = 0;
            end
            cur_w++;
            last_width = cur_w;
        end
        prev_hi = (bus.gtx_rx_reset_o === 1'b1);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, need %0d", name, act, exp);
    endtask

    task automatic wait_state(input int s, input int budget, input string name);
        int n = 0;
        while (int'(bus.state_o) != s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            $display("FAIL %s: timeout waiting for state %0d, got %0d", name, s, bus.state_o);
        end
    endtask

    task automatic settle_mon();
        @(posedge clk);
        #1;
    endtask

    int base;

    initial begin
        bus.enable_i = 0; bus.target_slide_i = 5'd2; bus.serdes_ready_i = 1;
        bus.synced_i = 1; bus.bitslide_i = 5'd2;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("rst_state", int'(bus.state_o), 0);
        check("rst_gtx_reset", int'(bus.gtx_rx_reset_o), 0);
        check("rst_locked", int'(bus.locked_o), 0);
        check("rst_fail", int'(bus.fail_o), 0);
        check("rst_retry", int'(bus.retry_cnt_o), 0);

        // 1: immediate match
        bus.enable_i = 1;
        wait_state(6, 100, "t1_lock");
        settle_mon();
        check("t1_locked", int'(bus.locked_o), 1);
        check("t1_retry", int'(bus.retry_cnt_o), 0);
        check("t1_no_pulse", pulse_cnt, 0);

        // 2: slides 5,7,2
        @(negedge clk); bus.enable_i = 0;
        @(negedge clk); base = pulse_cnt; bus.bitslide_i = 5'd5; bus.enable_i = 1;
        wait_state(5, 100, "t2_rst1");
        bus.bitslide_i = 5'd7;
        wait_state(1, 100, "t2_rdy1");
        wait_state(5, 100, "t2_rst2");
        bus.bitslide_i = 5'd2;
        wait_state(6, 100, "t2_lock");
        settle_mon();
        check("t2_pulses", pulse_cnt - base, 2);
        check("t2_width", last_width, 16);
        check("t2_retry", int'(bus.retry_cnt_o), 2);
        check("t2_locked", int'(bus.locked_o), 1);

        // 3: stuck slide exhausts retries
        @(negedge clk); bus.enable_i = 0;
        @(negedge clk); base = pulse_cnt; bus.bitslide_i = 5'd4; bus.enable_i = 1;
        wait_state(7, 1000, "t3_fail");
        settle_mon();
        check("t3_pulses", pulse_cnt - base, 3);
        check("t3_fail", int'(bus.fail_o), 1);
        check("t3_state", int'(bus.state_o), 7);
        check("t3_retry", int'(bus.retry_cnt_o), 3);
        @(negedge clk); bus.enable_i = 0;
        @(negedge clk);
        check("t3_idle", int'(bus.state_o), 0);
        check("t3_fail_clr", int'(bus.fail_o), 0);
        check("t3_retry_clr", int'(bus.retry_cnt_o), 0);

        // 4: sync timeout
        base = pulse_cnt; bus.synced_i = 0; bus.bitslide_i = 5'd2; bus.enable_i = 1;
        wait_state(5, 300, "t4_rst1");
        wait_state(1, 100, "t4_rdy1");
        wait_state(5, 300, "t4_rst2");
        settle_mon();
        check("t4_pulses", pulse_cnt - base, 2);
        check("t4_period", last_period, 117);
        check("t4_retry", int'(bus.retry_cnt_o), 2);
        @(negedge clk); bus.synced_i = 1;
        wait_state(6, 200, "t4_lock");
        settle_mon();
        check("t4_locked", int'(bus.locked_o), 1);
        check("t4_retry_lock", int'(bus.retry_cnt_o), 2);

        // 5: one-cycle sync loss then relock
        @(negedge clk); bus.synced_i = 0;
        @(negedge clk); bus.synced_i = 1;
        check("t5_unlock", int'(bus.locked_o), 0);
        check("t5_retry_clr", int'(bus.retry_cnt_o), 0);
        check("t5_state", int'(bus.state_o), 1);
        wait_state(6, 100, "t5_relock");
        settle_mon();
        check("t5_relocked", int'(bus.locked_o), 1);
`ifdef EVR_PHASE_LOCK_STATS_EN
        check("t5_loss_cnt", int'(bus.lock_loss_cnt_o), 1);
        check("t5_last_slide", int'(bus.last_slide_o), 2);
`endif

        // 6: disable mid-RESET, then reset mid-LOCKED
        @(negedge clk); bus.enable_i = 0;
        @(negedge clk); bus.bitslide_i = 5'd9; bus.enable_i = 1;
        wait_state(5, 100, "t6_rst");
        repeat (4) @(negedge clk);
        bus.enable_i = 0;
        @(negedge clk);
        check("t6_gtx_low", int'(bus.gtx_rx_reset_o), 0);
        check("t6_idle", int'(bus.state_o), 0);
        check("t6_width", last_width, 5);
        bus.bitslide_i = 5'd2; bus.enable_i = 1;
        wait_state(6, 100, "t6_lock");
        @(negedge clk); rst = 1;
        @(negedge clk);
        check("t6_rst_state", int'(bus.state_o), 0);
        check("t6_rst_locked", int'(bus.locked_o), 0);
        check("t6_rst_gtx", int'(bus.gtx_rx_reset_o), 0);
        check("t6_rst_retry", int'(bus.retry_cnt_o), 0);
`ifdef EVR_PHASE_LOCK_STATS_EN
        check("t6_rst_loss", int'(bus.lock_loss_cnt_o), 0);
`endif
        rst = 0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
